decode_stage_rv32: RTL and testbench
====================================

DECODE_STAGE_RV32 -- requirements
Module: decode_stage_rv32

Interface
REQ-001 Parameter DATAW, default 32: datapath, PC and immediate width.
REQ-002 Parameter ENABLE_M, default 1: when 1, RV32M multiply/divide instructions decode as legal.
REQ-003 Parameter ALUW, default (ENABLE_M ? 5 : 4): ALU code width.
REQ-004 clock  in  1  single clock; all state updates on the rising edge.
REQ-005 nReset  in  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  in  1  an instruction is offered.
REQ-007 in_ready  out  1  the stage accepts an offered instruction this cycle.
REQ-008 ins  in  32  raw instruction word.
REQ-009 in_pc  in  DATAW  address of ins.
REQ-010 flush  in  1  discard all held and incoming instructions.
REQ-011 out_valid  out  1  decoded bundle is valid.
REQ-012 out_ready  in  1  downstream consumes the bundle this cycle.
REQ-013 out_pc  out  DATAW  PC of the bundle.
REQ-014 rs1, rs2, rd  out  5 each  register addresses from ins[19:15], ins[24:20] and ins[11:7].
REQ-015 ctrl  out  decode_ctrl_t  reg_write, link_write, branch_type[2:0], test_branch, always_branch, absolute_branch, use_imm, use_pc, alu_code[ALUW-1:0], ram_write, ram_read.
REQ-016 imm  out  DATAW  sign-extended I/S/B/U/J immediate selected by opcode.
REQ-017 illegal  out  1  the bundle holds an unsupported encoding.

Function
REQ-018 Decode SHALL be combinational on ins/in_pc; the decoded result SHALL be registered, giving exactly 1 cycle of latency from acceptance to out_valid.
REQ-019 Transfer SHALL occur on in_valid&in_ready (input) and out_valid&out_ready (output); nothing transfers otherwise.
REQ-020 Storage SHALL be an output register plus one skid entry; in_ready SHALL equal !skid_valid and be driven from a flop.
REQ-021 An accepted bundle SHALL load the output register if it is empty or consumed this cycle, otherwise the skid entry.
REQ-022 On output consume with skid_valid, the skid bundle SHALL move to the output register; bundles SHALL leave in acceptance order.
REQ-023 flush SHALL clear out_valid and skid_valid at the next edge, and an instruction accepted in the flush cycle SHALL be dropped.
REQ-024 OP-IMM: alu_code = {0, ins[30] if funct3==5 else 0, funct3}; use_imm=1; reg_write=1.
REQ-025 OP: funct7 0x00/0x20 gives {0, ins[30], funct3}; funct7 0x01 with ENABLE_M gives {1, 0, funct3}.
REQ-026 LUI=CPY, AUIPC=ADD with use_pc, JAL=CPY with always_branch and link_write, JALR=ADD with absolute_branch, BRANCH=ADD with use_pc and test_branch, LOAD=ADD with ram_read, STORE=ADD with ram_write and the S immediate.
REQ-027 illegal SHALL be 1 for any of: unknown opcode; OP funct7 outside the allowed set; funct7 0x20 with funct3 other than 0 or 5; OP-IMM funct3 1 with funct7 != 0; OP-IMM funct3 5 with funct7 not 0 or 0x20; BRANCH funct3 2 or 3; LOAD funct3 3, 6 or 7; STORE funct3 > 2; JALR funct3 != 0.
REQ-028 An illegal bundle SHALL still be delivered, with reg_write, link_write, branch flags, ram_write and ram_read forced to 0.
REQ-029 Simultaneous accept and consume with the skid empty SHALL hold in_ready at 1, giving full throughput.

Reset
REQ-030 While nReset is low: out_valid=0, skid_valid=0, in_ready=1, and out_pc, rs1/rs2/rd, ctrl, imm and illegal all 0.
REQ-031 Reset mid-transfer SHALL discard held bundles with no partial output.

Structure
REQ-032 decode_ctrl_t, the opcode constants, the ALU codes (ADD, CPY) and the branch codes SHALL live in a shared package rv32_decode_pkg.
REQ-033 The combinational decoder SHALL be one sub-module, rv32_decode_comb; the stage module holds only the handshake and storage.

Verification
REQ-034 ADDI x1,x0,-1 (0xFFF00093) -> next cycle out_valid=1, rd=1, rs1=0, imm=0xFFFFFFFF, use_imm=1, reg_write=1, alu_code=0.
REQ-035 SRAI x2,x2,3 (0x40315113) -> alu_code=0x0D, illegal=0.
REQ-036 MUL x3,x1,x2 (0x022081B3) -> ENABLE_M=1: alu_code=5'b10000, reg_write=1; ENABLE_M=0: illegal=1, reg_write=0.
REQ-037 out_ready=0 with three back-to-back offers -> two accepted, in_ready=0 after the second; raising out_ready releases them in order, then accepts the third.
REQ-038 Both entries full and flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the offered instruction never appears.
REQ-039 nReset dropped while out_valid=1 -> out_valid=0 without waiting for a clock edge; after release, the first accepted instruction appears 1 cycle later.

Source files
------------

// File: rtl/rv32_decode_pkg.sv
// Shared RV32 decode types: opcodes, ALU/branch codes and the decoded control bundle.
package rv32_decode_pkg;

  localparam int unsigned ALU_CODE_W = 5;
  localparam int unsigned REG_W      = 5;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;

  localparam logic [ALU_CODE_W-1:0] ALU_ADD = 5'h00;
  localparam logic [ALU_CODE_W-1:0] ALU_CPY = 5'h0F;

  localparam logic [2:0] BR_EQ  = 3'd0;
  localparam logic [2:0] BR_NE  = 3'd1;
  localparam logic [2:0] BR_LT  = 3'd4;
  localparam logic [2:0] BR_GE  = 3'd5;
  localparam logic [2:0] BR_LTU = 3'd6;
  localparam logic [2:0] BR_GEU = 3'd7;

  typedef struct packed {
    logic                  reg_write;
    logic                  link_write;
    logic [2:0]            branch_type;
    logic                  test_branch;
    logic                  always_branch;
    logic                  absolute_branch;
    logic                  use_imm;
    logic                  use_pc;
    logic [ALU_CODE_W-1:0] alu_code;
    logic                  ram_write;
    logic                  ram_read;
  } decode_ctrl_t;

  typedef struct packed {
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    decode_ctrl_t     ctrl;
    logic             illegal;
  } decode_fields_t;

endpackage

// File: rtl/decode_stage_rv32_if.sv
// Upstream instruction handshake and downstream decoded-bundle handshake of the decode stage.
interface decode_stage_rv32_if
  import rv32_decode_pkg::*;
#(
  parameter int unsigned DATAW = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      ins;
  logic [DATAW-1:0] in_pc;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [DATAW-1:0] out_pc;
  logic [REG_W-1:0] rs1;
  logic [REG_W-1:0] rs2;
  logic [REG_W-1:0] rd;
  decode_ctrl_t     ctrl;
  logic [DATAW-1:0] imm;
  logic             illegal;

  modport master (
    output in_valid, ins, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, rs1, rs2, rd, ctrl, imm, illegal
  );

  modport slave (
    input  in_valid, ins, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, rs1, rs2, rd, ctrl, imm, illegal
  );
endinterface

// File: rtl/rv32_decode_comb.sv
// Purely combinational RV32I(+M) decoder: register fields, control bundle, immediate, legality.
module rv32_decode_comb
  import rv32_decode_pkg::*;
#(
  parameter int unsigned DATAW    = 32,
  parameter int unsigned ENABLE_M = 1,
  parameter int unsigned ALUW     = (ENABLE_M != 0) ? 5 : 4
) (
  input  logic [31:0]      ins,
  output decode_fields_t   fields_c,
  output logic [DATAW-1:0] imm_c
);

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic [31:0]           imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0]           imm32;
  logic [ALU_CODE_W-1:0] alu;
  decode_ctrl_t          ctrl;
  logic                  illegal;

  assign opcode = ins[6:0];
  assign funct3 = ins[14:12];
  assign funct7 = ins[31:25];
  assign imm_i  = {{20{ins[31]}}, ins[31:20]};
  assign imm_s  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_u  = {ins[31:12], 12'h000};
  assign imm_j  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

  always_comb begin
    ctrl    = '0;
    alu     = ALU_ADD;
    imm32   = '0;
    illegal = 1'b0;
    case (opcode)
      OPC_OP_IMM: begin
        ctrl.reg_write = 1'b1;
        ctrl.use_imm   = 1'b1;
        imm32          = imm_i;
        alu            = {1'b0, (funct3 == 3'd5) ? ins[30] : 1'b0, funct3};
        if (funct3 == 3'd1 && funct7 != 7'h00) illegal = 1'b1;
        if (funct3 == 3'd5 && funct7 != 7'h00 && funct7 != 7'h20) illegal = 1'b1;
      end
      OPC_OP: begin
        ctrl.reg_write = 1'b1;
        case (funct7)
          7'h00: alu = {2'b00, funct3};
          7'h20: begin
            alu = {2'b01, funct3};
            if (funct3 != 3'd0 && funct3 != 3'd5) illegal = 1'b1;
          end
          7'h01: begin
            alu = {2'b10, funct3};
            if (ENABLE_M == 0) illegal = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      OPC_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.use_imm   = 1'b1;
        alu            = ALU_CPY;
        imm32          = imm_u;
      end
      OPC_AUIPC: begin
        ctrl.reg_write = 1'b1;
        ctrl.use_imm   = 1'b1;
        ctrl.use_pc    = 1'b1;
        imm32          = imm_u;
      end
      OPC_JAL: begin
        ctrl.reg_write     = 1'b1;
        ctrl.link_write    = 1'b1;
        ctrl.always_branch = 1'b1;
        ctrl.use_imm       = 1'b1;
        alu                = ALU_CPY;
        imm32              = imm_j;
      end
      OPC_JALR: begin
        ctrl.reg_write       = 1'b1;
        ctrl.link_write      = 1'b1;
        ctrl.absolute_branch = 1'b1;
        ctrl.use_imm         = 1'b1;
        imm32                = imm_i;
        if (funct3 != 3'd0) illegal = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl.test_branch = 1'b1;
        ctrl.use_pc      = 1'b1;
        ctrl.use_imm     = 1'b1;
        ctrl.branch_type = funct3;
        imm32            = imm_b;
        case (funct3)
          BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU: illegal = 1'b0;
          default:                                    illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        ctrl.reg_write = 1'b1;
        ctrl.ram_read  = 1'b1;
        ctrl.use_imm   = 1'b1;
        imm32          = imm_i;
        if (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7) illegal = 1'b1;
      end
      OPC_STORE: begin
        ctrl.ram_write = 1'b1;
        ctrl.use_imm   = 1'b1;
        imm32          = imm_s;
        if (funct3 > 3'd2) illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    ctrl.alu_code = ALU_CODE_W'(alu[ALUW-1:0]);
    // Illegal bundles still flow downstream but must not change architectural state.
    if (illegal) begin
      ctrl.reg_write       = 1'b0;
      ctrl.link_write      = 1'b0;
      ctrl.test_branch     = 1'b0;
      ctrl.always_branch   = 1'b0;
      ctrl.absolute_branch = 1'b0;
      ctrl.ram_write       = 1'b0;
      ctrl.ram_read        = 1'b0;
    end
  end

  assign fields_c.rs1     = ins[19:15];
  assign fields_c.rs2     = ins[24:20];
  assign fields_c.rd      = ins[11:7];
  assign fields_c.ctrl    = ctrl;
  assign fields_c.illegal = illegal;
  assign imm_c            = DATAW'($signed(imm32));

endmodule

// File: rtl/decode_stage_rv32.sv
// RV32 decode pipeline stage: combinational decode into an output register backed by one skid entry.
module decode_stage_rv32
  import rv32_decode_pkg::*;
#(
  parameter int unsigned DATAW    = 32,
  parameter int unsigned ENABLE_M = 1,
  parameter int unsigned ALUW     = (ENABLE_M != 0) ? 5 : 4
) (
  input logic               clock,
  input logic               nReset,
  decode_stage_rv32_if.slave bus
);

  decode_fields_t   dec_fields_c;
  logic [DATAW-1:0] dec_imm_c;

  rv32_decode_comb #(
    .DATAW    (DATAW),
    .ENABLE_M (ENABLE_M),
    .ALUW     (ALUW)
  ) u_dec (
    .ins      (bus.ins),
    .fields_c (dec_fields_c),
    .imm_c    (dec_imm_c)
  );

  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  decode_fields_t   out_fields_q, out_fields_d;
  logic [DATAW-1:0] out_imm_q, out_imm_d;
  logic [DATAW-1:0] out_pc_q, out_pc_d;
  logic             skid_valid_q, skid_valid_d;
  decode_fields_t   skid_fields_q, skid_fields_d;
  logic [DATAW-1:0] skid_imm_q, skid_imm_d;
  logic [DATAW-1:0] skid_pc_q, skid_pc_d;
  logic             accept_c, consume_c;

  // Accept/consume bookkeeping; skid only fills when the output slot is held.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_fields_d  = out_fields_q;
    out_imm_d     = out_imm_q;
    out_pc_d      = out_pc_q;
    skid_valid_d  = skid_valid_q;
    skid_fields_d = skid_fields_q;
    skid_imm_d    = skid_imm_q;
    skid_pc_d     = skid_pc_q;
    accept_c      = bus.in_valid & in_ready_q;
    consume_c     = out_valid_q & bus.out_ready;
    if (bus.flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (consume_c && skid_valid_q) begin
      out_fields_d = skid_fields_q;
      out_imm_d    = skid_imm_q;
      out_pc_d     = skid_pc_q;
      skid_valid_d = 1'b0;
    end else if (accept_c && (!out_valid_q || consume_c)) begin
      out_valid_d  = 1'b1;
      out_fields_d = dec_fields_c;
      out_imm_d    = dec_imm_c;
      out_pc_d     = bus.in_pc;
    end else if (accept_c) begin
      skid_valid_d  = 1'b1;
      skid_fields_d = dec_fields_c;
      skid_imm_d    = dec_imm_c;
      skid_pc_d     = bus.in_pc;
    end else if (consume_c) begin
      out_valid_d = 1'b0;
    end
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_fields_q  <= '0;
      out_imm_q     <= '0;
      out_pc_q      <= '0;
      skid_valid_q  <= 1'b0;
      skid_fields_q <= '0;
      skid_imm_q    <= '0;
      skid_pc_q     <= '0;
    end else begin
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      out_fields_q  <= out_fields_d;
      out_imm_q     <= out_imm_d;
      out_pc_q      <= out_pc_d;
      skid_valid_q  <= skid_valid_d;
      skid_fields_q <= skid_fields_d;
      skid_imm_q    <= skid_imm_d;
      skid_pc_q     <= skid_pc_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_pc    = out_pc_q;
  assign bus.rs1       = out_fields_q.rs1;
  assign bus.rs2       = out_fields_q.rs2;
  assign bus.rd        = out_fields_q.rd;
  assign bus.ctrl      = out_fields_q.ctrl;
  assign bus.imm       = out_imm_q;
  assign bus.illegal   = out_fields_q.illegal;

endmodule

// File: tb/tb_decode_stage_rv32.sv
// Scoreboard bench for decode_stage_rv32: directed instruction vectors, backpressure, flush and reset.
module tb_decode_stage_rv32;
  import rv32_decode_pkg::*;

  typedef struct packed {
    logic [31:0]    pc;
    decode_fields_t f;
    logic [31:0]    imm;
  } exp_t;

  localparam int NV = 11;

  logic clk;
  logic nReset;

  decode_stage_rv32_if #(.DATAW(32)) bus ();

  decode_stage_rv32 #(.DATAW(32), .ENABLE_M(1)) u_dut (
    .clock  (clk),
    .nReset (nReset),
    .bus    (bus)
  );

  logic [31:0]    nm_ins;
  decode_fields_t nm_fields;
  logic [31:0]    nm_imm;

  rv32_decode_comb #(.DATAW(32), .ENABLE_M(0)) u_nom (
    .ins      (nm_ins),
    .fields_c (nm_fields),
    .imm_c    (nm_imm)
  );

  int             n_tests = 0;
  int             n_fail  = 0;
  int             n_out   = 0;
  int             cur_idx = 0;
  exp_t           sb_q[$];
  logic [31:0]    vec_ins [NV];
  decode_fields_t vec_f   [NV];
  logic [31:0]    vec_imm [NV];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic decode_ctrl_t mk_ctrl(input logic rw, input logic lw, input logic [2:0] bt,
                                           input logic tbr, input logic abr, input logic absb,
                                           input logic ui, input logic up, input logic [4:0] alu,
                                           input logic wr, input logic rdm);
    decode_ctrl_t c;
    c.reg_write = rw;   c.link_write = lw;      c.branch_type = bt;
    c.test_branch = tbr; c.always_branch = abr; c.absolute_branch = absb;
    c.use_imm = ui;     c.use_pc = up;          c.alu_code = alu;
    c.ram_write = wr;   c.ram_read = rdm;
    return c;
  endfunction

  function automatic decode_fields_t mk_f(input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [4:0] rd, input decode_ctrl_t c, input logic ill);
    decode_fields_t f;
    f.rs1 = rs1; f.rs2 = rs2; f.rd = rd; f.ctrl = c; f.illegal = ill;
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input int idx, input logic [31:0] pc);
    bus.in_valid = 1'b1;
    bus.ins      = vec_ins[idx];
    bus.in_pc    = pc;
    cur_idx      = idx;
  endtask

  // Monitor pops and compares on output transfer, then records flush/acceptance for this edge.
  always @(negedge clk) begin
    exp_t act, e;
    if (nReset) begin
      if (bus.out_valid && bus.out_ready) begin
        act = {bus.out_pc, bus.rs1, bus.rs2, bus.rd, bus.ctrl, bus.illegal, bus.imm};
        n_out++;
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_bundle: got %h expected none", act);
        end else begin
          e = sb_q.pop_front();
          if (act !== e) begin
            n_fail++;
            $display("FAIL bundle_%0d: got %h expected %h", n_out, act, e);
          end
        end
      end
      if (bus.flush) sb_q.delete();
      else if (bus.in_valid && bus.in_ready) begin
        e.pc  = bus.in_pc;
        e.f   = vec_f[cur_idx];
        e.imm = vec_imm[cur_idx];
        sb_q.push_back(e);
      end
    end
  end

  initial begin
    vec_ins[0]  = 32'hFFF00093; vec_imm[0]  = 32'hFFFFFFFF;
    vec_f[0]  = mk_f(5'd0, 5'd31, 5'd1, mk_ctrl(1, 0, 3'd0, 0, 0, 0, 1, 0, 5'h00, 0, 0), 1'b0);
    vec_ins[1]  = 32'h40315113; vec_imm[1]  = 32'h00000403;
    vec_f[1]  = mk_f(5'd2, 5'd3, 5'd2, mk_ctrl(1, 0, 3'd0, 0, 0, 0, 1, 0, 5'h0D, 0, 0), 1'b0);
    vec_ins[2]  = 32'h022081B3; vec_imm[2]  = 32'h00000000;
    vec_f[2]  = mk_f(5'd1, 5'd2, 5'd3, mk_ctrl(1, 0, 3'd0, 0, 0, 0, 0, 0, 5'h10, 0, 0), 1'b0);
    vec_ins[3]  = 32'h123452B7; vec_imm[3]  = 32'h12345000;
    vec_f[3]  = mk_f(5'd8, 5'd3, 5'd5, mk_ctrl(1, 0, 3'd0, 0, 0, 0, 1, 0, 5'h0F, 0, 0), 1'b0);
    vec_ins[4]  = 32'h0020A423; vec_imm[4]  = 32'h00000008;
    vec_f[4]  = mk_f(5'd1, 5'd2, 5'd8, mk_ctrl(0, 0, 3'd0, 0, 0, 0, 1, 0, 5'h00, 1, 0), 1'b0);
    vec_ins[5]  = 32'hFE208EE3; vec_imm[5]  = 32'hFFFFFFFC;
    vec_f[5]  = mk_f(5'd1, 5'd2, 5'd29, mk_ctrl(0, 0, 3'd0, 1, 0, 0, 1, 1, 5'h00, 0, 0), 1'b0);
    vec_ins[6]  = 32'h00013083; vec_imm[6]  = 32'h00000000;
    vec_f[6]  = mk_f(5'd2, 5'd0, 5'd1, mk_ctrl(0, 0, 3'd0, 0, 0, 0, 1, 0, 5'h00, 0, 0), 1'b1);
    vec_ins[7]  = 32'h008000EF; vec_imm[7]  = 32'h00000008;
    vec_f[7]  = mk_f(5'd0, 5'd8, 5'd1, mk_ctrl(1, 1, 3'd0, 0, 1, 0, 1, 0, 5'h0F, 0, 0), 1'b0);
    vec_ins[8]  = 32'h00000000; vec_imm[8]  = 32'h00000000;
    vec_f[8]  = mk_f(5'd0, 5'd0, 5'd0, mk_ctrl(0, 0, 3'd0, 0, 0, 0, 0, 0, 5'h00, 0, 0), 1'b1);
    vec_ins[9]  = 32'h40209133; vec_imm[9]  = 32'h00000000;
    vec_f[9]  = mk_f(5'd1, 5'd2, 5'd2, mk_ctrl(0, 0, 3'd0, 0, 0, 0, 0, 0, 5'h09, 0, 0), 1'b1);
    vec_ins[10] = 32'h00001217; vec_imm[10] = 32'h00001000;
    vec_f[10] = mk_f(5'd0, 5'd0, 5'd4, mk_ctrl(1, 0, 3'd0, 0, 0, 0, 1, 1, 5'h00, 0, 0), 1'b0);

    nReset        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.ins       = 32'h0;
    bus.in_pc     = 32'h0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    nm_ins        = 32'h0;

    // Reset values
    tick(); tick();
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_in_ready",  32'(bus.in_ready),  32'h1);
    check("rst_out_pc",    bus.out_pc,         32'h0);
    check("rst_imm",       bus.imm,            32'h0);
    check("rst_ctrl",      32'(bus.ctrl),      32'h0);
    check("rst_regs",      32'({bus.rs1, bus.rs2, bus.rd, bus.illegal}), 32'h0);
    nReset = 1'b1;
    tick();

    // ADDI: one cycle of latency, then consumed
    bus.out_ready = 1'b1;
    offer(0, 32'h0000_0100);
    tick();
    bus.in_valid = 1'b0;
    check("addi_latency_valid", 32'(bus.out_valid), 32'h1);
    check("addi_rd",            32'(bus.rd),        32'h1);
    tick();
    check("addi_consumed", 32'(bus.out_valid), 32'h0);

    // Full-rate stream of all vectors
    for (int i = 0; i < NV; i++) begin
      offer(i, 32'h0000_1000 + 32'(4 * i));
      tick();
      check("stream_in_ready", 32'(bus.in_ready), 32'h1);
    end
    bus.in_valid = 1'b0;
    tick(); tick();

    // Backpressure: two accepted, third waits, release in order
    bus.out_ready = 1'b0;
    offer(1, 32'h0000_2000);
    tick();
    check("bp_ready_after_1", 32'(bus.in_ready), 32'h1);
    offer(3, 32'h0000_2004);
    tick();
    check("bp_ready_after_2", 32'(bus.in_ready), 32'h0);
    check("bp_out_valid",     32'(bus.out_valid), 32'h1);
    offer(5, 32'h0000_2008);
    tick();
    check("bp_third_blocked", 32'(bus.in_ready), 32'h0);
    bus.out_ready = 1'b1;
    tick();
    check("bp_skid_drained", 32'(bus.in_ready), 32'h1);
    tick();
    bus.in_valid = 1'b0;
    tick(); tick();

    // Flush with both entries full and an offer pending
    bus.out_ready = 1'b0;
    offer(2, 32'h0000_3000);
    tick();
    offer(4, 32'h0000_3004);
    tick();
    check("fl_full", 32'(bus.in_ready), 32'h0);
    offer(7, 32'h0000_3008);
    bus.flush = 1'b1;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("fl_out_valid", 32'(bus.out_valid), 32'h0);
    check("fl_in_ready",  32'(bus.in_ready),  32'h1);
    bus.out_ready = 1'b1;
    tick(); tick(); tick();

    // Flush while an offer would otherwise be accepted
    bus.out_ready = 1'b0;
    offer(6, 32'h0000_4000);
    tick();
    offer(10, 32'h0000_4004);
    bus.flush = 1'b1;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("fl2_out_valid", 32'(bus.out_valid), 32'h0);
    bus.out_ready = 1'b1;
    tick(); tick(); tick();

    // Asynchronous reset with a bundle held
    bus.out_ready = 1'b0;
    offer(8, 32'h0000_5000);
    tick();
    bus.in_valid = 1'b0;
    check("rr_held", 32'(bus.out_valid), 32'h1);
    #2;
    nReset = 1'b0;
    sb_q.delete();
    #1;
    check("rr_async_valid", 32'(bus.out_valid), 32'h0);
    check("rr_async_ready", 32'(bus.in_ready),  32'h1);
    tick();
    nReset = 1'b1;
    tick();
    offer(9, 32'h0000_6000);
    tick();
    bus.in_valid = 1'b0;
    check("rr_first_after", 32'(bus.out_valid), 32'h1);
    bus.out_ready = 1'b1;
    tick(); tick();

    // Decoder built without the M extension
    nm_ins = 32'h022081B3;
    #1;
    check("nom_mul_illegal",   32'(nm_fields.illegal),        32'h1);
    check("nom_mul_reg_write", 32'(nm_fields.ctrl.reg_write), 32'h0);
    nm_ins = 32'h40315113;
    #1;
    check("nom_srai_legal", 32'(nm_fields.illegal),         32'h0);
    check("nom_srai_alu",   32'(nm_fields.ctrl.alu_code),   32'h0D);

    tick(); tick();
    check("sb_drained", 32'(sb_q.size()), 32'h0);
    check("out_count",  32'(n_out),       32'(1 + NV + 3 + 1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
